// File: rtl/cmd_time_scheduler.sv
// cmd_time_scheduler
// Scans the command register memory, compares each entry's TIME_START with
// TIME_NOW, hands due commands to the impulse generator (valid/ready), then
// asks the command writer to erase the slot (req/ack).
//
// Ports:
//   CLK, rst          clock, synchronous active-high reset
//   EN                scan enable
//   TIME_NOW          64-bit system time
//   MEM_RD_ADDR/RDEN  memory read request; MEM_Q returns RD_LAT cycles later
//   CLR_REQ/ADDR/ACK  slot-erase handshake with the writer
//   CMD_VALID/READY   command handshake; CMD_* carry the captured entry
//   BUSY              high whenever the scheduler is not idle
//   LATE_CNT          saturating count of dropped late commands
//
// Optional feature: define CMD_LATE_DROP_EN to drop (erase without issuing)
// entries more than LATE_LIMIT ticks late; this also adds the LATE_CNT port.
module cmd_time_scheduler #(
  parameter int unsigned N_IDX      = 255,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned LATE_LIMIT = 1000
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              EN,
  input  logic [63:0]       TIME_NOW,
  output logic [ADDR_W-1:0] MEM_RD_ADDR,
  output logic              MEM_RDEN,
  input  logic [337:0]      MEM_Q,
  output logic              CLR_REQ,
  output logic [ADDR_W-1:0] CLR_ADDR,
  input  logic              CLR_ACK,
  output logic              CMD_VALID,
  input  logic              CMD_READY,
  output logic [63:0]       CMD_TIME_START,
  output logic [47:0]       CMD_FREQ,
  output logic [47:0]       CMD_FREQ_STEP,
  output logic [31:0]       CMD_FREQ_RATE,
  output logic [15:0]       CMD_N_IMPULSE,
  output logic [1:0]        CMD_TYPE,
  output logic [31:0]       CMD_TI,
  output logic [31:0]       CMD_TP,
  output logic [31:0]       CMD_TBLANK1,
  output logic [31:0]       CMD_TBLANK2,
  output logic              BUSY
`ifdef CMD_LATE_DROP_EN
  ,
  output logic [15:0]       LATE_CNT
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WAIT, S_EVAL, S_ISSUE, S_CLEAR, S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          wait_q, wait_d;
  logic [337:0]        cmd_q, cmd_d;

  logic [63:0] ts_w;
  logic        empty_w;
  logic        due_w;

  assign ts_w    = MEM_Q[337:274];
  assign empty_w = &ts_w;
  assign due_w   = !empty_w && (TIME_NOW >= ts_w);

`ifdef CMD_LATE_DROP_EN
  logic [15:0] late_q, late_d;
  logic        late_w;
  assign late_w   = (TIME_NOW - ts_w) > 64'(LATE_LIMIT);
  assign LATE_CNT = late_q;
`else
  logic unused_late_limit;
  assign unused_late_limit = ^LATE_LIMIT;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    cmd_d   = cmd_q;
`ifdef CMD_LATE_DROP_EN
    late_d  = late_q;
`endif
    case (state_q)
      S_IDLE:  if (EN) state_d = S_RD;
      S_RD: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 2'(RD_LAT - 1)) state_d = S_EVAL;
        else                          wait_d  = wait_q + 2'd1;
      end
      S_EVAL: begin
        if (due_w) begin
`ifdef CMD_LATE_DROP_EN
          if (late_w) begin
            // late entries go straight to erase and never reach the generator
            state_d = S_CLEAR;
            if (late_q != '1) late_d = late_q + 16'd1;
          end else begin
            cmd_d   = MEM_Q;
            state_d = S_ISSUE;
          end
`else
          cmd_d   = MEM_Q;
          state_d = S_ISSUE;
`endif
        end else begin
          state_d = S_NEXT;
        end
      end
      S_ISSUE: if (CMD_READY) state_d = S_CLEAR;
      S_CLEAR: if (CLR_ACK)   state_d = S_NEXT;
      S_NEXT: begin
        addr_d  = (addr_q == ADDR_W'(N_IDX)) ? '0 : addr_q + ADDR_W'(1);
        state_d = EN ? S_RD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
      cmd_q   <= '0;
`ifdef CMD_LATE_DROP_EN
      late_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
`ifdef CMD_LATE_DROP_EN
      late_q  <= late_d;
`endif
    end
  end

  // Handshake outputs decode the registered state, so a reset clears them
  // on the very next cycle with nothing left half-issued.
  assign MEM_RD_ADDR = addr_q;
  assign MEM_RDEN    = (state_q == S_RD);
  assign CMD_VALID   = (state_q == S_ISSUE);
  assign CLR_REQ     = (state_q == S_CLEAR);
  assign CLR_ADDR    = (state_q == S_CLEAR) ? addr_q : '0;
  assign BUSY        = (state_q != S_IDLE);

  assign CMD_TIME_START = cmd_q[337:274];
  assign CMD_FREQ       = cmd_q[273:226];
  assign CMD_FREQ_STEP  = cmd_q[225:178];
  assign CMD_FREQ_RATE  = cmd_q[177:146];
  assign CMD_N_IMPULSE  = cmd_q[145:130];
  assign CMD_TYPE       = cmd_q[129:128];
  assign CMD_TI         = cmd_q[127:96];
  assign CMD_TP         = cmd_q[95:64];
  assign CMD_TBLANK1    = cmd_q[63:32];
  assign CMD_TBLANK2    = cmd_q[31:0];

endmodule
